conv_frame_sequencer: RTL and testbench
=======================================

// Module: conv_frame_sequencer
// PURPOSE
//  Sequences the 3x3 convolution datapath that sits between the HDMI receiver and transmitter.
//  Tracks decoded video timing (de/vsync) in the pixel-clock domain and drives the line-buffer write port.
//  Produces window-valid and pixel coordinates for the MAC array.
//  Holds kernel coefficients in a shadow bank and applies new coefficients only at frame boundaries,
//  so no frame is ever filtered with a mixed kernel.
// PARAMETERS
//  KSIZE     3     kernel edge length; NLB = KSIZE-1 line buffers
//  H_ACTIVE  1280  active pixels per line
//  V_ACTIVE  720   active lines per frame
//  XW        11    pixel-column counter width
//  YW        10    line counter width
//  CW        8     coefficient width, two's complement
// PORTS
//  pclk         in   1            pixel clock from the HDMI receiver
//  RSTBTN       in   1            asynchronous, active-high reset
//  de           in   1            decoded data-enable, active-high
//  vsync        in   1            decoded vsync, active-high
//  cfg_wr       in   1            write one shadow coefficient
//  cfg_addr     in   4            coefficient index 0..KSIZE*KSIZE-1; higher indices ignored
//  cfg_data     in   CW           coefficient value
//  cfg_commit   in   1            request shadow->active copy at next frame start
//  cfg_pending  out  1            commit requested, not yet applied
//  coef_flat    out  KSIZE*KSIZE*CW  active coefficients; index i at bits [i*CW +: CW]
//  lb_we        out  1            line-buffer write enable
//  lb_addr      out  XW           line-buffer column address
//  lb_wsel      out  2            line buffer written this line, 0..NLB-1
//  win_valid    out  1            current window complete (x>=KSIZE-1 and y>=KSIZE-1)
//  pix_x        out  XW           column of the current pixel
//  pix_y        out  YW           line of the current pixel
//  frame_start  out  1            one-cycle pulse on the first active pixel of a frame
//  err_geom     out  1            sticky; line or frame length differed from H_ACTIVE/V_ACTIVE
// BEHAVIOUR
//  Reset values: all outputs 0.
//   coef_flat resets to identity: centre coefficient = 1, all others 0; shadow bank resets the same.
//  Registered outputs; every output lags the de/vsync sample that causes it by exactly 1 cycle.
//  FSM states:
//   WAIT_VS -> SYNC on vsync rising edge (vsync 0 -> 1 between consecutive samples).
//   SYNC    -> ACTIVE on de=1.
//   ACTIVE  -> HBLANK on de=0.
//   HBLANK  -> ACTIVE on de=1.
//   HBLANK  -> SYNC on vsync rising edge.
//  Frame start: on SYNC->ACTIVE, assert frame_start and set pix_x=0, pix_y=0, lb_wsel=0.
//   If cfg_pending=1 in the same cycle, copy shadow->coef_flat and clear cfg_pending.
//  ACTIVE (each cycle): lb_we=1, lb_addr=pix_x; pix_x increments per pixel.
//  ACTIVE->HBLANK: if pix_x+1 != H_ACTIVE, set err_geom.
//   Then pix_y increments, pix_x clears, and lb_wsel advances modulo NLB (wraps NLB-1 -> 0).
//  Vsync rising edge in HBLANK: if lines seen != V_ACTIVE, set err_geom.
//  Vsync rising edge in ACTIVE: set err_geom and go to SYNC; de is ignored until the next SYNC->ACTIVE.
//  Width rules:
//   A pixel beyond H_ACTIVE-1 saturates pix_x at H_ACTIVE-1, drops lb_we, and sets err_geom.
//   pix_y saturates at V_ACTIVE-1.
//  win_valid = ACTIVE && pix_x>=KSIZE-1 && pix_y>=KSIZE-1; lb_we=0 in every state except ACTIVE.
//  Config writes:
//   cfg_wr updates shadow[cfg_addr] on the same edge; a write is never blocked.
//   A write in the same cycle as a commit copy is not included in that copy.
//   cfg_commit sets cfg_pending; a repeated commit while pending is a no-op.
//  Reset mid-frame: returns to WAIT_VS and clears err_geom; the first partial frame is never flagged.
// TESTING
//  1. Reset, then 3 frames of 8x6 (H_ACTIVE=8, V_ACTIVE=6) with 4-cycle hblank.
//     Expect frame_start once per frame and lb_addr 0..7 each line.
//     Expect lb_wsel sequence 0,1,0,1,0,1 per line and win_valid on x>=2, y>=2 (24 pixels/frame).
//  2. Write coef idx0=5, then commit mid-frame.
//     Expect coef_flat unchanged until the next frame_start, then idx0=5 on that cycle; cfg_pending 1 -> 0.
//  3. cfg_wr idx4=-3 issued in the same cycle as the commit copy.
//     Expect the active centre coefficient to stay at the old value; the next commit applies -3.
//  4. One line of 7 pixels: expect err_geom=1 from the cycle after that line ends.
//     Expect the remaining lines to stay counted.
//  5. Vsync asserted mid-line: expect err_geom=1, lb_we=0, and a clean frame_start on the next frame.
//  6. RSTBTN pulsed mid-line: expect all outputs 0 on the next edge, identity coefficients, and FSM in WAIT_VS.

Source files
------------

// File: rtl/conv_frame_sequencer.sv
// Pixel-clock sequencer for the 3x3 convolution path: tracks de/vsync timing, drives the
// line-buffer write port, produces window/coordinate info and swaps kernels only at frame start.
module conv_frame_sequencer #(
    parameter int KSIZE    = 3,
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int XW       = 11,
    parameter int YW       = 10,
    parameter int CW       = 8
) (
    input  logic                      pclk,
    input  logic                      RSTBTN,
    input  logic                      de,
    input  logic                      vsync,
    input  logic                      cfg_wr,
    input  logic [3:0]                cfg_addr,
    input  logic [CW-1:0]             cfg_data,
    input  logic                      cfg_commit,
    output logic                      cfg_pending,
    output logic [KSIZE*KSIZE*CW-1:0] coef_flat,
    output logic                      lb_we,
    output logic [XW-1:0]             lb_addr,
    output logic [1:0]                lb_wsel,
    output logic                      win_valid,
    output logic [XW-1:0]             pix_x,
    output logic [YW-1:0]             pix_y,
    output logic                      frame_start,
    output logic                      err_geom
);
    localparam int NK     = KSIZE * KSIZE;
    localparam int NLB    = KSIZE - 1;
    localparam int CENTRE = NK / 2;
    localparam logic [XW-1:0] X_LAST    = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0] X_LEN     = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_LAST    = YW'(V_ACTIVE - 1);
    localparam logic [YW:0]   Y_LEN     = (YW + 1)'(V_ACTIVE);
    localparam logic [1:0]    WSEL_LAST = 2'(NLB - 1);
    localparam logic [3:0]    ADDR_LIM  = 4'(NK);

    typedef enum logic [1:0] {WAIT_VS, SYNC, ACTIVE, HBLANK} state_t;

    state_t          state_q;
    logic            vs_prev_q;
    logic [XW-1:0]   pix_x_q;
    logic [XW-1:0]   lb_addr_q;
    logic [YW-1:0]   pix_y_q;
    logic [YW:0]     lines_q;
    logic [1:0]      wsel_q;
    logic            lb_we_q;
    logic            win_q;
    logic            fs_q;
    logic            err_q;
    logic            pend_q;
    logic [CW-1:0]   shadow_q [NK];
    logic [CW-1:0]   coef_q [NK];

    logic            vs_rise_d;
    logic            copy_d;
    logic [XW-1:0]   pix_x_inc_d;
    logic [YW-1:0]   pix_y_next_d;
    logic [YW:0]     lines_next_d;
    logic [1:0]      wsel_next_d;

    function automatic logic [CW-1:0] identity_coef(input int idx);
        return (idx == CENTRE) ? CW'(1) : {CW{1'b0}};
    endfunction

    function automatic logic win_at(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (x >= XW'(KSIZE - 1)) && (y >= YW'(KSIZE - 1));
    endfunction

    // Edge detect and saturating/wrapping next values for the counters
    always_comb begin
        vs_rise_d   = vsync & ~vs_prev_q;
        copy_d      = (state_q == SYNC) && de && pend_q;
        pix_x_inc_d = pix_x_q + XW'(1);
        if (pix_y_q == Y_LAST) begin
            pix_y_next_d = pix_y_q;
        end else begin
            pix_y_next_d = pix_y_q + YW'(1);
        end
        if (&lines_q) begin
            lines_next_d = lines_q;
        end else begin
            lines_next_d = lines_q + (YW + 1)'(1);
        end
        if (wsel_q == WSEL_LAST) begin
            wsel_next_d = 2'b00;
        end else begin
            wsel_next_d = wsel_q + 2'b01;
        end
    end

    // Timing FSM with registered line-buffer, window and geometry outputs
    always_ff @(posedge pclk or posedge RSTBTN) begin
        if (RSTBTN) begin
            state_q   <= WAIT_VS;
            vs_prev_q <= 1'b0;
            pix_x_q   <= {XW{1'b0}};
            lb_addr_q <= {XW{1'b0}};
            pix_y_q   <= {YW{1'b0}};
            lines_q   <= {(YW + 1){1'b0}};
            wsel_q    <= 2'b00;
            lb_we_q   <= 1'b0;
            win_q     <= 1'b0;
            fs_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            vs_prev_q <= vsync;
            fs_q      <= 1'b0;
            lb_we_q   <= 1'b0;
            win_q     <= 1'b0;
            case (state_q)
                WAIT_VS: begin
                    if (vs_rise_d) state_q <= SYNC;
                end
                SYNC: begin
                    if (de) begin
                        state_q   <= ACTIVE;
                        fs_q      <= 1'b1;
                        pix_x_q   <= {XW{1'b0}};
                        pix_y_q   <= {YW{1'b0}};
                        wsel_q    <= 2'b00;
                        lines_q   <= {(YW + 1){1'b0}};
                        lb_we_q   <= 1'b1;
                        lb_addr_q <= {XW{1'b0}};
                        win_q     <= win_at({XW{1'b0}}, {YW{1'b0}});
                    end
                end
                ACTIVE: begin
                    if (vs_rise_d) begin
                        err_q   <= 1'b1;
                        state_q <= SYNC;
                    end else if (de) begin
                        // Overlong line: pin the column and stop writing
                        if (pix_x_q == X_LAST) begin
                            err_q     <= 1'b1;
                            lb_addr_q <= pix_x_q;
                            win_q     <= win_at(pix_x_q, pix_y_q);
                        end else begin
                            pix_x_q   <= pix_x_inc_d;
                            lb_addr_q <= pix_x_inc_d;
                            lb_we_q   <= 1'b1;
                            win_q     <= win_at(pix_x_inc_d, pix_y_q);
                        end
                    end else begin
                        if (pix_x_inc_d != X_LEN) err_q <= 1'b1;
                        state_q <= HBLANK;
                        pix_x_q <= {XW{1'b0}};
                        pix_y_q <= pix_y_next_d;
                        wsel_q  <= wsel_next_d;
                        lines_q <= lines_next_d;
                    end
                end
                HBLANK: begin
                    if (vs_rise_d) begin
                        if (lines_q != Y_LEN) err_q <= 1'b1;
                        state_q <= SYNC;
                    end else if (de) begin
                        state_q   <= ACTIVE;
                        pix_x_q   <= {XW{1'b0}};
                        lb_we_q   <= 1'b1;
                        lb_addr_q <= {XW{1'b0}};
                        win_q     <= win_at({XW{1'b0}}, pix_y_q);
                    end
                end
                default: state_q <= WAIT_VS;
            endcase
        end
    end

    // Shadow coefficient bank; writes are always accepted
    always_ff @(posedge pclk or posedge RSTBTN) begin
        if (RSTBTN) begin
            for (int i = 0; i < NK; i++) shadow_q[i] <= identity_coef(i);
        end else if (cfg_wr && (cfg_addr < ADDR_LIM)) begin
            shadow_q[cfg_addr] <= cfg_data;
        end
    end

    // Active bank copy at frame start; the copy sees the shadow before any same-edge write
    always_ff @(posedge pclk or posedge RSTBTN) begin
        if (RSTBTN) begin
            for (int i = 0; i < NK; i++) coef_q[i] <= identity_coef(i);
            pend_q <= 1'b0;
        end else if (copy_d) begin
            for (int i = 0; i < NK; i++) coef_q[i] <= shadow_q[i];
            pend_q <= 1'b0;
        end else if (cfg_commit) begin
            pend_q <= 1'b1;
        end
    end

    // Flatten the active bank onto the output bus
    always_comb begin
        coef_flat = {(NK * CW){1'b0}};
        for (int i = 0; i < NK; i++) coef_flat[i*CW +: CW] = coef_q[i];
    end

    assign cfg_pending = pend_q;
    assign lb_we       = lb_we_q;
    assign lb_addr     = lb_addr_q;
    assign lb_wsel     = wsel_q;
    assign win_valid   = win_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = fs_q;
    assign err_geom    = err_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer on an 8x6 frame geometry.
module tb_conv_frame_sequencer;
    localparam int KSIZE = 3;
    localparam int H     = 8;
    localparam int V     = 6;
    localparam int XW    = 11;
    localparam int YW    = 10;
    localparam int CW    = 8;
    localparam logic [71:0] COEF_ID = 72'h000000000100000000;
    localparam logic [71:0] COEF_C1 = 72'h000000000100000005;
    localparam logic [71:0] COEF_C2 = 72'h00000000FD00000005;

    logic          pclk = 1'b0;
    logic          RSTBTN;
    logic          de;
    logic          vsync;
    logic          cfg_wr;
    logic [3:0]    cfg_addr;
    logic [CW-1:0] cfg_data;
    logic          cfg_commit;
    logic          cfg_pending;
    logic [71:0]   coef_flat;
    logic          lb_we;
    logic [XW-1:0] lb_addr;
    logic [1:0]    lb_wsel;
    logic          win_valid;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          frame_start;
    logic          err_geom;

    int errors = 0;
    int checks = 0;

    conv_frame_sequencer #(
        .KSIZE(KSIZE), .H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW), .CW(CW)
    ) dut (
        .pclk(pclk), .RSTBTN(RSTBTN), .de(de), .vsync(vsync),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
        .cfg_pending(cfg_pending), .coef_flat(coef_flat), .lb_we(lb_we), .lb_addr(lb_addr),
        .lb_wsel(lb_wsel), .win_valid(win_valid), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .err_geom(err_geom)
    );

    always #5 pclk = ~pclk;

    task automatic tick(input logic d, input logic v);
        de    = d;
        vsync = v;
        @(posedge pclk);
        #1;
    endtask

    task automatic pixels(input int n);
        repeat (n) tick(1'b1, 1'b0);
    endtask

    task automatic hblank();
        repeat (4) tick(1'b0, 1'b0);
    endtask

    task automatic vs_pulse();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic rest_of_frame();
        pixels(7);
        hblank();
        repeat (5) begin
            pixels(8);
            hblank();
        end
    endtask

    task automatic test_reset();
        logic [39:0] got;
        RSTBTN = 1'b1;
        @(posedge pclk);
        #1;
        got = {cfg_pending, lb_we, lb_addr, lb_wsel, win_valid, pix_x, pix_y, frame_start, err_geom};
        checks++;
        if (got !== 40'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", got);
        end
        checks++;
        if (coef_flat !== COEF_ID) begin
            errors++;
            $display("FAIL reset_coef: got %h want %h", coef_flat, COEF_ID);
        end
        RSTBTN = 1'b0;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        checks++;
        if ({lb_we, frame_start} !== 2'b00) begin
            errors++;
            $display("FAIL wait_vs_idle: got lb_we/fs=%b want 00", {lb_we, frame_start});
        end
    endtask

    task automatic test_frames();
        logic [36:0] got;
        logic [36:0] exp;
        logic [22:0] hgot;
        logic [22:0] hexp;
        int fs_cnt;
        int win_cnt;
        int bad_px;
        int bad_hb;
        fs_cnt  = 0;
        win_cnt = 0;
        bad_px  = 0;
        bad_hb  = 0;
        tick(1'b0, 1'b0);
        for (int f = 0; f < 3; f++) begin
            vs_pulse();
            for (int l = 0; l < V; l++) begin
                for (int x = 0; x < H; x++) begin
                    tick(1'b1, 1'b0);
                    got = {lb_we, lb_addr, pix_x, pix_y, lb_wsel, win_valid, frame_start};
                    exp = {1'b1, XW'(x), XW'(x), YW'(l), 2'(l % 2),
                           (x >= 2 && l >= 2), (x == 0 && l == 0)};
                    fs_cnt  += int'(frame_start);
                    win_cnt += int'(win_valid);
                    if (got !== exp && bad_px < 4) begin
                        bad_px++;
                        $display("FAIL pixel f%0d l%0d x%0d: got %h want %h", f, l, x, got, exp);
                    end
                end
                tick(1'b0, 1'b0);
                hgot = {lb_we, win_valid, pix_x, pix_y};
                hexp = {1'b0, 1'b0, XW'(0), YW'((l < V - 1) ? l + 1 : V - 1)};
                if (hgot !== hexp && bad_hb < 4) begin
                    bad_hb++;
                    $display("FAIL hblank f%0d l%0d: got %h want %h", f, l, hgot, hexp);
                end
                repeat (3) tick(1'b0, 1'b0);
            end
        end
        checks++;
        if (bad_px != 0) errors++;
        checks++;
        if (bad_hb != 0) errors++;
        checks++;
        if (fs_cnt != 3) begin
            errors++;
            $display("FAIL frame_start_count: got %0d want 3", fs_cnt);
        end
        checks++;
        if (win_cnt != 72) begin
            errors++;
            $display("FAIL win_valid_count: got %0d want 72", win_cnt);
        end
        checks++;
        if (err_geom !== 1'b0) begin
            errors++;
            $display("FAIL clean_frames_err: got %b want 0", err_geom);
        end
    endtask

    task automatic test_commit();
        vs_pulse();
        cfg_wr   = 1'b1;
        cfg_addr = 4'd0;
        cfg_data = 8'd5;
        tick(1'b0, 1'b0);
        cfg_wr = 1'b0;
        tick(1'b1, 1'b0);
        pixels(7);
        hblank();
        pixels(8);
        hblank();
        cfg_commit = 1'b1;
        tick(1'b0, 1'b0);
        cfg_commit = 1'b0;
        checks++;
        if (cfg_pending !== 1'b1) begin
            errors++;
            $display("FAIL commit_pending: got %b want 1", cfg_pending);
        end
        repeat (4) begin
            pixels(8);
            hblank();
        end
        vs_pulse();
        checks++;
        if (coef_flat !== COEF_ID) begin
            errors++;
            $display("FAIL coef_held_midframe: got %h want %h", coef_flat, COEF_ID);
        end
        tick(1'b1, 1'b0);
        checks++;
        if ({frame_start, cfg_pending, coef_flat} !== {1'b1, 1'b0, COEF_C1}) begin
            errors++;
            $display("FAIL commit_apply: got fs=%b pend=%b coef=%h want fs=1 pend=0 coef=%h",
                     frame_start, cfg_pending, coef_flat, COEF_C1);
        end
        rest_of_frame();
    endtask

    task automatic test_same_cycle();
        cfg_commit = 1'b1;
        tick(1'b0, 1'b0);
        cfg_commit = 1'b0;
        vs_pulse();
        cfg_wr   = 1'b1;
        cfg_addr = 4'd4;
        cfg_data = 8'hFD;
        tick(1'b1, 1'b0);
        cfg_wr = 1'b0;
        checks++;
        if ({frame_start, cfg_pending, coef_flat} !== {1'b1, 1'b0, COEF_C1}) begin
            errors++;
            $display("FAIL same_cycle_copy: got fs=%b pend=%b coef=%h want fs=1 pend=0 coef=%h",
                     frame_start, cfg_pending, coef_flat, COEF_C1);
        end
        rest_of_frame();
        cfg_commit = 1'b1;
        tick(1'b0, 1'b0);
        cfg_commit = 1'b0;
        vs_pulse();
        tick(1'b1, 1'b0);
        checks++;
        if (coef_flat !== COEF_C2) begin
            errors++;
            $display("FAIL second_commit: got %h want %h", coef_flat, COEF_C2);
        end
        rest_of_frame();
        checks++;
        if (err_geom !== 1'b0) begin
            errors++;
            $display("FAIL config_frames_err: got %b want 0", err_geom);
        end
    endtask

    task automatic test_short_line();
        vs_pulse();
        tick(1'b1, 1'b0);
        pixels(7);
        hblank();
        pixels(7);
        checks++;
        if (err_geom !== 1'b0) begin
            errors++;
            $display("FAIL short_line_early: got %b want 0", err_geom);
        end
        tick(1'b0, 1'b0);
        checks++;
        if ({err_geom, pix_y} !== {1'b1, YW'(2)}) begin
            errors++;
            $display("FAIL short_line_err: got err=%b y=%0d want err=1 y=2", err_geom, pix_y);
        end
        repeat (3) tick(1'b0, 1'b0);
        pixels(8);
        hblank();
        checks++;
        if (pix_y !== YW'(3)) begin
            errors++;
            $display("FAIL short_line_count: got y=%0d want 3", pix_y);
        end
        pixels(3);
    endtask

    task automatic test_reset_midline();
        logic [39:0] got;
        RSTBTN = 1'b1;
        #1;
        got = {cfg_pending, lb_we, lb_addr, lb_wsel, win_valid, pix_x, pix_y, frame_start, err_geom};
        checks++;
        if ({got, coef_flat} !== {40'h0, COEF_ID}) begin
            errors++;
            $display("FAIL midline_reset: got outs=%h coef=%h want 0 and %h", got, coef_flat, COEF_ID);
        end
        RSTBTN = 1'b0;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        checks++;
        if ({lb_we, frame_start, err_geom} !== 3'b000) begin
            errors++;
            $display("FAIL midline_wait_vs: got %b want 000", {lb_we, frame_start, err_geom});
        end
    endtask

    task automatic test_vsync_midline();
        logic [25:0] got;
        vs_pulse();
        tick(1'b1, 1'b0);
        pixels(7);
        hblank();
        pixels(4);
        tick(1'b0, 1'b1);
        checks++;
        if ({err_geom, lb_we, frame_start} !== 3'b100) begin
            errors++;
            $display("FAIL vsync_abort: got err/we/fs=%b want 100", {err_geom, lb_we, frame_start});
        end
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        got = {frame_start, lb_we, lb_addr, pix_y, lb_wsel, win_valid};
        checks++;
        if (got !== {1'b1, 1'b1, XW'(0), YW'(0), 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL restart_after_abort: got %h want %h", got,
                     {1'b1, 1'b1, XW'(0), YW'(0), 2'b00, 1'b0});
        end
    endtask

    task automatic test_overflow();
        RSTBTN = 1'b1;
        tick(1'b0, 1'b0);
        RSTBTN = 1'b0;
        vs_pulse();
        tick(1'b1, 1'b0);
        pixels(7);
        checks++;
        if ({pix_x, lb_we, err_geom} !== {XW'(7), 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL last_pixel: got x=%0d we=%b err=%b want 7 1 0", pix_x, lb_we, err_geom);
        end
        tick(1'b1, 1'b0);
        checks++;
        if ({pix_x, lb_we, err_geom} !== {XW'(7), 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL overflow_pixel: got x=%0d we=%b err=%b want 7 0 1", pix_x, lb_we, err_geom);
        end
        tick(1'b0, 1'b0);
        checks++;
        if ({pix_x, pix_y} !== {XW'(0), YW'(1)}) begin
            errors++;
            $display("FAIL overflow_line_end: got x=%0d y=%0d want 0 1", pix_x, pix_y);
        end
    endtask

    initial begin
        de         = 1'b0;
        vsync      = 1'b0;
        cfg_wr     = 1'b0;
        cfg_addr   = 4'd0;
        cfg_data   = 8'd0;
        cfg_commit = 1'b0;
        RSTBTN     = 1'b1;
        test_reset();
        test_frames();
        test_commit();
        test_same_cycle();
        test_short_line();
        test_reset_midline();
        test_vsync_midline();
        test_overflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
